// File: rtl/prd_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// prd_pkg : shared definitions for the PRD descriptor-file write arbiter.
//   PRD_TAG_W / PRD_DATA_W : default physical-index and descriptor widths
//   prd_tag_t / prd_data_t : typedefs at those default widths
//   prd_wport_t            : one write port {ack, tag, data}
//   prd_wrap()             : single-step modulo wrap used by the round-robin scan
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package prd_pkg;
    localparam int PRD_TAG_W  = 6;
    localparam int PRD_DATA_W = 3;

    typedef logic [PRD_TAG_W-1:0]  prd_tag_t;
    typedef logic [PRD_DATA_W-1:0] prd_data_t;

    typedef struct packed {
        logic      ack;
        prd_tag_t  tag;
        prd_data_t data;
    } prd_wport_t;

    // value is always < 2*modulus in the scan, so one subtraction suffices
    function automatic int prd_wrap(input int value, input int modulus);
        return (value >= modulus) ? value - modulus : value;
    endfunction
endpackage

// File: rtl/prd_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// prd_write_arbiter_if : requester/write-port bundle of the PRD write arbiter.
//   en, commitAllow        : global enable and commit-stage write permission
//   reqValid/Tag/Data      : packed requester inputs, requester 0 in the LSBs
//   reqReady               : combinational per-requester grant
//   writeAck/Select/Data   : registered write-port outputs, port 0 in the LSBs
// Modports: master = requester/commit side, slave = arbiter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface prd_write_arbiter_if
    import prd_pkg::*;
#(
    parameter int NUM_REQ   = 6,
    parameter int NUM_PORTS = 4,
    parameter int TAG_W     = PRD_TAG_W,
    parameter int DATA_W    = PRD_DATA_W
);
    logic                        en;
    logic                        commitAllow;
    logic [NUM_REQ-1:0]          reqValid;
    logic [NUM_REQ*TAG_W-1:0]    reqTag;
    logic [NUM_REQ*DATA_W-1:0]   reqData;
    logic [NUM_REQ-1:0]          reqReady;
    logic [NUM_PORTS-1:0]        writeAck;
    logic [NUM_PORTS*TAG_W-1:0]  writeSelect;
    logic [NUM_PORTS*DATA_W-1:0] writeData;

    modport master (
        output en, commitAllow, reqValid, reqTag, reqData,
        input  reqReady, writeAck, writeSelect, writeData
    );

    modport slave (
        input  en, commitAllow, reqValid, reqTag, reqData,
        output reqReady, writeAck, writeSelect, writeData
    );
endinterface

// File: rtl/prd_rr_picker.sv
// -----------------------------------------------------------------------------
// prd_rr_picker : combinational round-robin selector with same-tag suppression.
//   i_enable    : when 0 no grants are made
//   i_valid     : per-requester valid
//   i_tag       : per-requester target index
//   i_ptr       : requester the scan starts from
//   o_grant     : per-requester grant
//   o_port_vld  : port p carries a grant this cycle
//   o_port_idx  : requester index assigned to port p
//   o_next_ptr  : pointer for the next cycle (i_ptr when nothing was granted)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module prd_rr_picker
    import prd_pkg::*;
#(
    parameter int NUM_REQ   = 6,
    parameter int NUM_PORTS = 4,
    parameter int TAG_W     = PRD_TAG_W,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                                 i_enable,
    input  logic [NUM_REQ-1:0]                   i_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]        i_tag,
    input  logic [IDX_W-1:0]                     i_ptr,
    output logic [NUM_REQ-1:0]                   o_grant,
    output logic [NUM_PORTS-1:0]                 o_port_vld,
    output logic [NUM_PORTS-1:0][IDX_W-1:0]      o_port_idx,
    output logic [IDX_W-1:0]                     o_next_ptr
);
    int                          w_cnt;
    int                          w_idx;
    logic                        w_cand_vld;
    logic [TAG_W-1:0]            w_cand_tag;
    logic                        w_clash;
    logic [NUM_PORTS-1:0][TAG_W-1:0] w_slot_tag;

    always_comb begin
        o_grant    = '0;
        o_port_vld = '0;
        o_port_idx = '0;
        o_next_ptr = i_ptr;
        w_cnt      = 0;
        w_idx      = 0;
        w_cand_vld = 1'b0;
        w_cand_tag = '0;
        w_clash    = 1'b0;
        w_slot_tag = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx      = prd_wrap(int'(i_ptr) + k, NUM_REQ);
            w_cand_vld = 1'b0;
            w_cand_tag = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (r == w_idx) begin
                    w_cand_vld = i_valid[r];
                    w_cand_tag = i_tag[r];
                end
            end
            // Comparing only against already-granted slots is enough: an earlier
            // valid same-tag request is either granted, itself blocked by an even
            // earlier granted one, or the ports are already full.
            w_clash = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (p < w_cnt && w_slot_tag[p] == w_cand_tag) begin
                    w_clash = 1'b1;
                end
            end
            if (i_enable && w_cand_vld && !w_clash && w_cnt < NUM_PORTS) begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (r == w_idx) begin
                        o_grant[r] = 1'b1;
                    end
                end
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (p == w_cnt) begin
                        o_port_vld[p] = 1'b1;
                        o_port_idx[p] = IDX_W'(w_idx);
                        w_slot_tag[p] = w_cand_tag;
                    end
                end
                o_next_ptr = IDX_W'(prd_wrap(w_idx + 1, NUM_REQ));
                w_cnt      = w_cnt + 1;
            end
        end
    end
endmodule

// File: rtl/prd_write_arbiter.sv
// -----------------------------------------------------------------------------
// prd_write_arbiter : grants up to NUM_PORTS of NUM_REQ writeback requesters per
// cycle onto descriptor-file write ports, round-robin, one cycle of latency.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   bus       : prd_write_arbiter_if.slave (requests in, grants and ports out)
//   stallCount: (only with PRD_ARB_STALL_CNT_EN) saturating 16-bit count of
//               cycles in which some valid requester was not granted
// Optional feature macro: PRD_ARB_STALL_CNT_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module prd_write_arbiter
    import prd_pkg::*;
#(
    parameter int NUM_REQ   = 6,
    parameter int NUM_PORTS = 4,
    parameter int TAG_W     = PRD_TAG_W,
    parameter int DATA_W    = PRD_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    prd_write_arbiter_if.slave     bus
`ifdef PRD_ARB_STALL_CNT_EN
    ,
    output logic [15:0]            stallCount
`endif
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0][TAG_W-1:0]   w_req_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0]  w_req_data;
    logic                            w_enable;
    logic [NUM_REQ-1:0]              w_grant;
    logic [NUM_PORTS-1:0]            w_port_vld;
    logic [NUM_PORTS-1:0][IDX_W-1:0] w_port_idx;
    logic [IDX_W-1:0]                w_next_ptr;

    logic [IDX_W-1:0]                  r_rr_ptr;
    logic [NUM_PORTS-1:0]              r_ack;
    logic [NUM_PORTS-1:0][TAG_W-1:0]   r_sel;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  r_data;

    assign w_req_tag  = bus.reqTag;
    assign w_req_data = bus.reqData;

    // Reset is folded in so reqReady drops combinationally while reset is low.
    assign w_enable = bus.en & bus.commitAllow & reset;

    prd_rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .NUM_PORTS (NUM_PORTS),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W)
    ) u_picker (
        .i_enable   (w_enable),
        .i_valid    (bus.reqValid),
        .i_tag      (w_req_tag),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_port_vld (w_port_vld),
        .o_port_idx (w_port_idx),
        .o_next_ptr (w_next_ptr)
    );

    assign bus.reqReady = w_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
            r_ack    <= '0;
            r_sel    <= '0;
            r_data   <= '0;
        end else begin
            r_rr_ptr <= w_next_ptr;
            r_ack    <= w_port_vld;
            // idle ports keep their last select/data; only the ack drops
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_port_vld[p]) begin
                    r_sel[p]  <= w_req_tag[w_port_idx[p]];
                    r_data[p] <= w_req_data[w_port_idx[p]];
                end
            end
        end
    end

    assign bus.writeAck    = r_ack;
    assign bus.writeSelect = r_sel;
    assign bus.writeData   = r_data;

`ifdef PRD_ARB_STALL_CNT_EN
    logic        w_stall;
    logic [15:0] r_stall_cnt;

    assign w_stall = |(bus.reqValid & ~w_grant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stallCount = r_stall_cnt;
`endif
endmodule

// File: tb/tb_prd_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prd_write_arbiter : directed bench for prd_write_arbiter (default params).
// Inputs change 1 ns after the rising edge; comparisons happen before the next
// edge (combinational reqReady) or 1 ns after it (registered ports).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prd_write_arbiter;
    localparam int NR = 6;
    localparam int NP = 4;
    localparam int TW = 6;
    localparam int DW = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_run  = 0;
    int   n_fail = 0;

    logic [TW-1:0] tb_tag  [NR];
    logic [DW-1:0] tb_data [NR];

    prd_write_arbiter_if #(.NUM_REQ(NR), .NUM_PORTS(NP), .TAG_W(TW), .DATA_W(DW)) bus_if ();

`ifdef PRD_ARB_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    prd_write_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
`ifdef PRD_ARB_STALL_CNT_EN
        ,
        .stallCount (stall_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NR-1:0] valid);
        bus_if.reqValid = valid;
        for (int i = 0; i < NR; i++) begin
            bus_if.reqTag[i*TW +: TW]  = tb_tag[i];
            bus_if.reqData[i*DW +: DW] = tb_data[i];
        end
        #1;
    endtask

    task automatic do_reset();
        next_edge();
        reset = 1'b0;
        bus_if.reqValid = '0;
        next_edge();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        bus_if.en = 1'b1;
        bus_if.commitAllow = 1'b1;
        for (int i = 0; i < NR; i++) begin
            tb_tag[i]  = TW'(40 + i);
            tb_data[i] = DW'(i);
        end
        drive(6'b111111);
        #2;
        // reset state, with every requester valid
        chk("rst_ready", bus_if.reqReady, 6'b000000);
        chk("rst_ack",   bus_if.writeAck, 4'b0000);
        chk("rst_sel",   bus_if.writeSelect, 24'd0);
        chk("rst_data",  bus_if.writeData, 12'd0);
        chk("rst_ptr",   dut.r_rr_ptr, 3'd0);
        next_edge();
        chk("rst_ack_edge", bus_if.writeAck, 4'b0000);
        bus_if.reqValid = '0;
        reset = 1'b1;

        // three requesters from pointer 0
        tb_tag[0] = 6'd5;  tb_data[0] = 3'd1;
        tb_tag[1] = 6'd9;  tb_data[1] = 3'd2;
        tb_tag[2] = 6'd12; tb_data[2] = 3'd3;
        drive(6'b000111);
        chk("t1_ready", bus_if.reqReady, 6'b000111);
        next_edge();
        chk("t1_ack",  bus_if.writeAck, 4'b0111);
        chk("t1_sel",  bus_if.writeSelect, {6'd0, 6'd12, 6'd9, 6'd5});
        chk("t1_data", bus_if.writeData, {3'd0, 3'd3, 3'd2, 3'd1});
        chk("t1_ptr",  dut.r_rr_ptr, 3'd3);
        drive(6'b000000);
        next_edge();
        chk("t1_idle_ack", bus_if.writeAck, 4'b0000);
        chk("t1_idle_sel", bus_if.writeSelect, {6'd0, 6'd12, 6'd9, 6'd5});
        chk("t1_idle_ptr", dut.r_rr_ptr, 3'd3);

        // all six valid, pointer wrap
        do_reset();
        for (int i = 0; i < NR; i++) begin
            tb_tag[i]  = TW'(10 + i);
            tb_data[i] = DW'(i);
        end
        drive(6'b111111);
        chk("t2a_ready", bus_if.reqReady, 6'b001111);
        next_edge();
        chk("t2a_ack",  bus_if.writeAck, 4'b1111);
        chk("t2a_sel",  bus_if.writeSelect, {6'd13, 6'd12, 6'd11, 6'd10});
        chk("t2a_data", bus_if.writeData, {3'd3, 3'd2, 3'd1, 3'd0});
        chk("t2a_ptr",  dut.r_rr_ptr, 3'd4);
        tb_tag[0] = 6'd20; tb_data[0] = 3'd6;
        tb_tag[1] = 6'd21; tb_data[1] = 3'd7;
        tb_tag[2] = 6'd22; tb_data[2] = 3'd4;
        tb_tag[3] = 6'd23; tb_data[3] = 3'd5;
        drive(6'b111111);
        chk("t2b_ready", bus_if.reqReady, 6'b110011);
        next_edge();
        chk("t2b_ack",  bus_if.writeAck, 4'b1111);
        chk("t2b_sel",  bus_if.writeSelect, {6'd21, 6'd20, 6'd15, 6'd14});
        chk("t2b_data", bus_if.writeData, {3'd7, 3'd6, 3'd5, 3'd4});
        chk("t2b_ptr",  dut.r_rr_ptr, 3'd2);

        // same tag on requesters 1 and 3
        do_reset();
        tb_tag[1] = 6'd7; tb_data[1] = 3'd1;
        tb_tag[3] = 6'd7; tb_data[3] = 3'd2;
        drive(6'b001010);
        chk("t3a_ready", bus_if.reqReady, 6'b000010);
        next_edge();
        chk("t3a_ack",  bus_if.writeAck, 4'b0001);
        chk("t3a_sel",  bus_if.writeSelect, {18'd0, 6'd7});
        chk("t3a_data", bus_if.writeData, {9'd0, 3'd1});
        drive(6'b001000);
        chk("t3b_ready", bus_if.reqReady, 6'b001000);
        next_edge();
        chk("t3b_ack",  bus_if.writeAck, 4'b0001);
        chk("t3b_sel",  bus_if.writeSelect, {18'd0, 6'd7});
        chk("t3b_data", bus_if.writeData, {9'd0, 3'd2});

        // commit stall for three cycles
        do_reset();
        tb_tag[0] = 6'd1; tb_data[0] = 3'd3;
        tb_tag[1] = 6'd2; tb_data[1] = 3'd4;
        bus_if.commitAllow = 1'b0;
        drive(6'b000011);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t4_stall%0d_ready", c), bus_if.reqReady, 6'b000000);
            next_edge();
            chk($sformatf("t4_stall%0d_ack", c), bus_if.writeAck, 4'b0000);
            chk($sformatf("t4_stall%0d_ptr", c), dut.r_rr_ptr, 3'd0);
        end
`ifdef PRD_ARB_STALL_CNT_EN
        chk("t4_stall_count", stall_count, 16'd3);
`endif
        bus_if.commitAllow = 1'b1;
        drive(6'b000011);
        chk("t4_go_ready", bus_if.reqReady, 6'b000011);
        next_edge();
        chk("t4_go_ack",  bus_if.writeAck, 4'b0011);
        chk("t4_go_sel",  bus_if.writeSelect, {12'd0, 6'd2, 6'd1});
        chk("t4_go_data", bus_if.writeData, {6'd0, 3'd4, 3'd3});
        chk("t4_go_ptr",  dut.r_rr_ptr, 3'd2);
`ifdef PRD_ARB_STALL_CNT_EN
        chk("t4_go_count", stall_count, 16'd3);
`endif

        // asynchronous reset just after that grant, before the next edge
        #1;
        reset = 1'b0;
        #1;
        chk("t5_async_ack",   bus_if.writeAck, 4'b0000);
        chk("t5_async_sel",   bus_if.writeSelect, 24'd0);
        chk("t5_async_ready", bus_if.reqReady, 6'b000000);
        chk("t5_async_ptr",   dut.r_rr_ptr, 3'd0);
        #1;
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            tb_tag[i]  = TW'(30 + i);
            tb_data[i] = DW'(i);
        end
        drive(6'b111111);
        chk("t5_post_ready", bus_if.reqReady, 6'b001111);
        next_edge();
        chk("t5_post_sel", bus_if.writeSelect, {6'd33, 6'd32, 6'd31, 6'd30});
        chk("t5_post_ptr", dut.r_rr_ptr, 3'd4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
